// File: rtl/sp_matrix_streamer.sv
// Scratchpad drain stage: snapshots one matrix and streams a rows x cols window over valid/ready.
// Optional SP_STREAM_PARITY_EN adds a registered even-parity output parity_o alongside data_o.
module sp_matrix_streamer #(
  parameter int DW           = 8,
  parameter int BW           = 32,
  parameter int MAX_DIM      = BW / DW,
  parameter int Elements_Num = MAX_DIM * MAX_DIM,
  parameter int DIM_W        = $clog2(MAX_DIM) + 1
) (
  input  logic                       clk_i,
  input  logic                       reset_i,
  input  logic                       start_i,
  input  logic [1:0]                 mat_sel_i,
  input  logic [DIM_W-1:0]           dim_rows_i,
  input  logic [DIM_W-1:0]           dim_cols_i,
  output logic [1:0]                 mat_to_read_o,
  input  logic [BW*Elements_Num-1:0] mat_sp_i,
  output logic [BW-1:0]              data_o,
  output logic                       valid_o,
  input  logic                       ready_i,
  output logic                       last_o,
  output logic                       busy_o,
  output logic                       done_o
`ifdef SP_STREAM_PARITY_EN
  ,
  output logic                       parity_o
`endif
);

  localparam int IDX_W = (Elements_Num > 1) ? $clog2(Elements_Num) : 1;

  typedef enum logic [2:0] {
    S_IDLE,
    S_REQ,
    S_WAIT,
    S_STREAM,
    S_DONE
  } state_t;

  state_t           state_q, state_d;
  logic [1:0]       sel_q, sel_d;
  logic [DIM_W-1:0] rows_q, rows_d, cols_q, cols_d;
  logic [DIM_W-1:0] row_q, row_d, col_q, col_d;
  logic [BW-1:0]    data_q, data_d;
  logic             valid_q, valid_d;
  logic             last_q, last_d;
  logic             busy_q, busy_d;
  logic             done_q, done_d;
  logic [BW-1:0]    snap_q [Elements_Num];
  logic             beat;

  assign beat = valid_q & ready_i;

  function automatic logic [DIM_W-1:0] clamp_dim(input logic [DIM_W-1:0] d);
    if (d == '0 || d > DIM_W'(MAX_DIM)) return DIM_W'(MAX_DIM);
    return d;
  endfunction

  function automatic logic [IDX_W-1:0] elem_idx(input logic [DIM_W-1:0] r,
                                                input logic [DIM_W-1:0] c);
    return IDX_W'(r) * IDX_W'(MAX_DIM) + IDX_W'(c);
  endfunction

  // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
  always_ff @(posedge clk_i or posedge reset_i) begin
    if (reset_i) state_q <= S_IDLE;
    else         state_q <= state_d;
  end

  // NOTE: every comb output gets a default first; a missing branch would otherwise infer a latch.
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      S_IDLE:   if (start_i) state_d = S_REQ;
      S_REQ:    state_d = S_WAIT;
      S_WAIT:   state_d = S_STREAM;
      S_STREAM: if (beat && last_q) state_d = S_DONE;
      S_DONE:   state_d = S_IDLE;
      default:  state_d = S_IDLE;
    endcase
  end

  // NOTE: blocking assignments here let row_d/col_d feed the next-element lookup in the same pass.
  always_comb begin
    sel_d   = sel_q;
    rows_d  = rows_q;
    cols_d  = cols_q;
    row_d   = row_q;
    col_d   = col_q;
    data_d  = data_q;
    valid_d = valid_q;
    last_d  = last_q;
    done_d  = 1'b0;
    busy_d  = (state_d != S_IDLE);
    unique case (state_q)
      S_IDLE: begin
        if (start_i) begin
          sel_d  = mat_sel_i;
          rows_d = clamp_dim(dim_rows_i);
          cols_d = clamp_dim(dim_cols_i);
        end
      end
      S_WAIT: begin
        row_d   = '0;
        col_d   = '0;
        data_d  = mat_sp_i[0 +: BW];
        valid_d = 1'b1;
        last_d  = (rows_q == DIM_W'(1)) && (cols_q == DIM_W'(1));
      end
      S_STREAM: begin
        if (beat) begin
          if (last_q) begin
            valid_d = 1'b0;
            last_d  = 1'b0;
            done_d  = 1'b1;
          end else begin
            if (col_q == cols_q - DIM_W'(1)) begin
              col_d = '0;
              row_d = row_q + DIM_W'(1);
            end else begin
              col_d = col_q + DIM_W'(1);
            end
            data_d = snap_q[elem_idx(row_d, col_d)];
            last_d = (row_d == rows_q - DIM_W'(1)) && (col_d == cols_q - DIM_W'(1));
          end
        end
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk_i or posedge reset_i) begin
    if (reset_i) begin
      sel_q   <= '0;
      rows_q  <= '0;
      cols_q  <= '0;
      row_q   <= '0;
      col_q   <= '0;
      data_q  <= '0;
      valid_q <= 1'b0;
      last_q  <= 1'b0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      sel_q   <= sel_d;
      rows_q  <= rows_d;
      cols_q  <= cols_d;
      row_q   <= row_d;
      col_q   <= col_d;
      data_q  <= data_d;
      valid_q <= valid_d;
      last_q  <= last_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
    end
  end

  // NOTE: the snapshot is a small register array, so it is cleared on reset like any other state.
  always_ff @(posedge clk_i or posedge reset_i) begin
    if (reset_i) begin
      for (int k = 0; k < Elements_Num; k++) snap_q[k] <= '0;
    end else if (state_q == S_WAIT) begin
      for (int k = 0; k < Elements_Num; k++) snap_q[k] <= mat_sp_i[k*BW +: BW];
    end
  end

`ifdef SP_STREAM_PARITY_EN
  logic parity_q;
  always_ff @(posedge clk_i or posedge reset_i) begin
    if (reset_i) parity_q <= 1'b0;
    else         parity_q <= ^data_d;
  end
  assign parity_o = parity_q;
`endif

  assign mat_to_read_o = sel_q;
  assign data_o        = data_q;
  assign valid_o       = valid_q;
  assign last_o        = last_q;
  assign busy_o        = busy_q;
  assign done_o        = done_q;

endmodule

// File: tb/tb_sp_matrix_streamer.sv
// Scoreboard bench for sp_matrix_streamer: expected beats are queued at start and popped per beat.
module tb_sp_matrix_streamer;

  localparam int BW    = 32;
  localparam int MD    = 4;
  localparam int NE    = MD * MD;
  localparam int DIM_W = 3;

  typedef struct {
    logic [BW-1:0] d;
    logic          l;
  } beat_t;

  logic              clk_i = 1'b0;
  logic              reset_i = 1'b1;
  logic              start_i = 1'b0;
  logic [1:0]        mat_sel_i = '0;
  logic [DIM_W-1:0]  dim_rows_i = '0;
  logic [DIM_W-1:0]  dim_cols_i = '0;
  logic [1:0]        mat_to_read_o;
  logic [BW*NE-1:0]  mat_sp_i = '0;
  logic [BW-1:0]     data_o;
  logic              valid_o;
  logic              ready_i = 1'b0;
  logic              last_o;
  logic              busy_o;
  logic              done_o;
`ifdef SP_STREAM_PARITY_EN
  logic              parity_o;
`endif

  beat_t exp_q[$];
  int    checks = 0;
  int    passes = 0;

  sp_matrix_streamer dut (
    .clk_i        (clk_i),
    .reset_i      (reset_i),
    .start_i      (start_i),
    .mat_sel_i    (mat_sel_i),
    .dim_rows_i   (dim_rows_i),
    .dim_cols_i   (dim_cols_i),
    .mat_to_read_o(mat_to_read_o),
    .mat_sp_i     (mat_sp_i),
    .data_o       (data_o),
    .valid_o      (valid_o),
    .ready_i      (ready_i),
    .last_o       (last_o),
    .busy_o       (busy_o),
    .done_o       (done_o)
`ifdef SP_STREAM_PARITY_EN
    ,
    .parity_o     (parity_o)
`endif
  );

  always #5 clk_i = ~clk_i;

  task automatic cyc();
    @(posedge clk_i);
    #1;
  endtask

  function automatic int eff_dim(input logic [DIM_W-1:0] d);
    return (d == 0 || d > MD) ? MD : int'(d);
  endfunction

  // Loads the scratchpad image, issues start and queues the expected window; returns in cycle 3.
  task automatic start_run(input logic [1:0] sel, input logic [DIM_W-1:0] rows,
                           input logic [DIM_W-1:0] cols, input logic [BW-1:0] base);
    int r_eff, c_eff;
    beat_t b;
    r_eff = eff_dim(rows);
    c_eff = eff_dim(cols);
    for (int k = 0; k < NE; k++) mat_sp_i[k*BW +: BW] = base + BW'(k);
    for (int r = 0; r < r_eff; r++)
      for (int c = 0; c < c_eff; c++) begin
        b.d = base + BW'(r * MD + c);
        b.l = (r == r_eff - 1) && (c == c_eff - 1);
        exp_q.push_back(b);
      end
    mat_sel_i  = sel;
    dim_rows_i = rows;
    dim_cols_i = cols;
    start_i    = 1'b1;
    cyc();
    start_i    = 1'b0;
    mat_sel_i  = ~sel;
    dim_rows_i = DIM_W'($urandom_range(0, 7));
    dim_cols_i = DIM_W'($urandom_range(0, 7));
    for (int c = 1; c <= 2; c++) begin
      checks++;
      if (mat_to_read_o !== sel || busy_o !== 1'b1 || valid_o !== 1'b0)
        $display("FAIL start_c%0d: sel=%0d busy=%b valid=%b required sel=%0d busy=1 valid=0",
                 c, mat_to_read_o, busy_o, valid_o, sel);
      else passes++;
      cyc();
    end
  endtask

  // mode 0: ready always 1 (beats must be back-to-back); mode 1: ready pattern 1,0,0,1,0,1.
  task automatic drain(input int mode, input bit pulse, input logic [1:0] sel);
    bit            stalled;
    logic [BW-1:0] hold_d;
    logic          hold_l;
    int            guard, k;
    beat_t         e;
    bit            pat [6] = '{1, 0, 0, 1, 0, 1};
    stalled = 0;
    guard   = 0;
    k       = 0;
    hold_d  = '0;
    hold_l  = 1'b0;
    while (exp_q.size() > 0 && guard < 200) begin
      ready_i = (mode == 0) ? 1'b1 : pat[k % 6];
      start_i = pulse && (k == 3);
      if (k == 1) mat_sp_i = ~mat_sp_i;
      k++;
      if (stalled) begin
        checks++;
        if (valid_o !== 1'b1 || data_o !== hold_d || last_o !== hold_l)
          $display("FAIL hold: valid=%b data=%h last=%b required valid=1 data=%h last=%b",
                   valid_o, data_o, last_o, hold_d, hold_l);
        else passes++;
      end
      if (mode == 0) begin
        checks++;
        if (valid_o !== 1'b1) $display("FAIL gap: valid=%b required 1", valid_o);
        else passes++;
      end
      if (valid_o === 1'b1 && ready_i) begin
        e = exp_q.pop_front();
        checks++;
        if (data_o !== e.d || last_o !== e.l)
          $display("FAIL beat: data=%h last=%b required data=%h last=%b", data_o, last_o, e.d, e.l);
        else passes++;
`ifdef SP_STREAM_PARITY_EN
        checks++;
        if (parity_o !== ^e.d) $display("FAIL parity: got %b required %b", parity_o, ^e.d);
        else passes++;
`endif
        stalled = 0;
      end else if (valid_o === 1'b1) begin
        stalled = 1;
        hold_d  = data_o;
        hold_l  = last_o;
      end
      checks++;
      if (done_o !== 1'b0 || mat_to_read_o !== sel)
        $display("FAIL stream_ctl: done=%b sel=%0d required done=0 sel=%0d", done_o, mat_to_read_o, sel);
      else passes++;
      cyc();
      guard++;
    end
    start_i = 1'b0;
    if (guard >= 200) begin
      checks++;
      $display("FAIL timeout: %0d beats outstanding required 0", exp_q.size());
      exp_q.delete();
    end
    checks++;
    if (done_o !== 1'b1 || valid_o !== 1'b0 || last_o !== 1'b0 || busy_o !== 1'b1)
      $display("FAIL done_cycle: done=%b valid=%b last=%b busy=%b required 1 0 0 1",
               done_o, valid_o, last_o, busy_o);
    else passes++;
    start_i   = pulse;
    mat_sel_i = ~sel;
    cyc();
    start_i = 1'b0;
    for (int c = 0; c < 2; c++) begin
      checks++;
      if (done_o !== 1'b0 || busy_o !== 1'b0 || mat_to_read_o !== sel)
        $display("FAIL idle_%0d: done=%b busy=%b sel=%0d required done=0 busy=0 sel=%0d",
                 c, done_o, busy_o, mat_to_read_o, sel);
      else passes++;
      cyc();
    end
  endtask

  task automatic test_reset();
    #1;
    checks++;
    if (valid_o !== 0 || busy_o !== 0 || last_o !== 0 || done_o !== 0 || data_o !== '0 ||
        mat_to_read_o !== '0)
      $display("FAIL reset_state: valid=%b busy=%b last=%b done=%b data=%h sel=%0d required all 0",
               valid_o, busy_o, last_o, done_o, data_o, mat_to_read_o);
    else passes++;
    cyc();
    reset_i = 1'b0;
    cyc();
  endtask

  task automatic test_full_drain();
    start_run(2'd2, 3'd4, 3'd4, 32'h100);
    drain(0, 0, 2'd2);
  endtask

  task automatic test_window();
    start_run(2'd0, 3'd2, 3'd3, 32'h200);
    drain(0, 0, 2'd0);
  endtask

  task automatic test_backpressure();
    start_run(2'd1, 3'd4, 3'd4, 32'h300);
    drain(1, 0, 2'd1);
  endtask

  task automatic test_clamp();
    start_run(2'd3, 3'd0, 3'd0, 32'h400);
    drain(0, 0, 2'd3);
    start_run(2'd3, 3'd7, 3'd5, 32'h500);
    drain(1, 0, 2'd3);
  endtask

  task automatic test_reset_mid_stream();
    beat_t e;
    start_run(2'd2, 3'd4, 3'd4, 32'h600);
    ready_i = 1'b1;
    for (int i = 0; i < 4; i++) begin
      e = exp_q.pop_front();
      checks++;
      if (valid_o !== 1'b1 || data_o !== e.d)
        $display("FAIL pre_reset_beat: valid=%b data=%h required valid=1 data=%h", valid_o, data_o, e.d);
      else passes++;
      cyc();
    end
    #2;
    reset_i = 1'b1;
    #1;
    checks++;
    if (valid_o !== 0 || busy_o !== 0 || last_o !== 0 || done_o !== 0 || data_o !== '0 ||
        mat_to_read_o !== '0)
      $display("FAIL async_reset: valid=%b busy=%b last=%b done=%b data=%h sel=%0d required all 0",
               valid_o, busy_o, last_o, done_o, data_o, mat_to_read_o);
    else passes++;
    exp_q.delete();
    cyc();
    reset_i = 1'b0;
    cyc();
    checks++;
    if (busy_o !== 1'b0 || valid_o !== 1'b0)
      $display("FAIL post_reset_idle: busy=%b valid=%b required 0 0", busy_o, valid_o);
    else passes++;
  endtask

  task automatic test_collision();
    start_run(2'd1, 3'd4, 3'd4, 32'h700);
    drain(0, 1, 2'd1);
    test_reset_mid_stream();
    start_run(2'd3, 3'd1, 3'd1, 32'h800);
    drain(1, 0, 2'd3);
  endtask

  initial begin
    test_reset();
    test_full_drain();
    test_window();
    test_backpressure();
    test_clamp();
    test_collision();
    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end

endmodule
